// File: rtl/scroll_disp_pkg.sv
// Shared character codes, output idle levels and the code-to-segment map
// used by the scrolling-message display scanner.
package scroll_disp_pkg;

   localparam logic [3:0] CH_A     = 4'd0;
   localparam logic [3:0] CH_B     = 4'd1;
   localparam logic [3:0] CH_C     = 4'd2;
   localparam logic [3:0] CH_F     = 4'd3;
   localparam logic [3:0] CH_G     = 4'd4;
   localparam logic [3:0] CH_H     = 4'd5;
   localparam logic [3:0] CH_I     = 4'd6;
   localparam logic [3:0] CH_L     = 4'd7;
   localparam logic [3:0] CH_N     = 4'd8;
   localparam logic [3:0] CH_O     = 4'd9;
   localparam logic [3:0] CH_S     = 4'd10;
   localparam logic [3:0] CH_T     = 4'd11;
   localparam logic [3:0] CH_U     = 4'd12;
   localparam logic [3:0] CH_E     = 4'd13;
   localparam logic [3:0] CH_P     = 4'd14;
   localparam logic [3:0] CH_BLANK = 4'd15;

   localparam logic [7:0] SEG_OFF = 8'hFF;
   localparam logic [3:0] AN_OFF  = 4'hF;

   // Active-high {g,f,e,d,c,b,a} for each character code.
   function automatic logic [6:0] pat7(input logic [3:0] code);
      pat7 = 7'h00;
      case (code)
         CH_A:     pat7 = 7'h77;
         CH_B:     pat7 = 7'h7C;
         CH_C:     pat7 = 7'h39;
         CH_F:     pat7 = 7'h71;
         CH_G:     pat7 = 7'h3D;
         CH_H:     pat7 = 7'h76;
         CH_I:     pat7 = 7'h06;
         CH_L:     pat7 = 7'h38;
         CH_N:     pat7 = 7'h54;
         CH_O:     pat7 = 7'h5C;
         CH_S:     pat7 = 7'h6D;
         CH_T:     pat7 = 7'h78;
         CH_U:     pat7 = 7'h3E;
         CH_E:     pat7 = 7'h79;
         CH_P:     pat7 = 7'h73;
         CH_BLANK: pat7 = 7'h00;
         default:  pat7 = 7'h00;
      endcase
   endfunction

endpackage

// File: rtl/char_to_seg7.sv
// Combinational character code to active-low {dp,g..a} segment drive; dp held off.
// Zero latency, no flow control.
module char_to_seg7
   import scroll_disp_pkg::*;
(
   input  logic [3:0] i_code,
   output logic [7:0] o_seg
);

   assign o_seg = {1'b1, ~pat7(i_code)};

endmodule

// File: rtl/scroll_display_scan.sv
// Scans four latched character codes onto a multiplexed common-anode display and paces
// the upstream scroll with a one-cycle shift pulse; outputs are registered (1-cycle latency).
module scroll_display_scan
   import scroll_disp_pkg::*;
#(
   parameter int SCAN_DIV         = 25000,
   parameter int BLANK_CYC        = 500,
   parameter int FRAMES_PER_SHIFT = 50
)(
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_en,
   input  logic [3:0] i_c0,
   input  logic [3:0] i_c1,
   input  logic [3:0] i_c2,
   input  logic [3:0] i_c3,
   output logic [7:0] o_seg,
   output logic [3:0] o_an,
   output logic       o_shift_en
);

   localparam int PW = $clog2(SCAN_DIV);
   localparam int FW = $clog2(FRAMES_PER_SHIFT + 1);

   localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
   localparam logic [PW-1:0] BLANK_END  = PW'(BLANK_CYC);
   localparam logic [FW-1:0] FCNT_LAST  = FW'(FRAMES_PER_SHIFT - 1);

   logic [PW-1:0] r_presc;
   logic [1:0]    r_idx;
   logic [FW-1:0] r_fcnt;
   logic [3:0]    r_snap [4];
   logic [7:0]    r_seg;
   logic [3:0]    r_an;
   logic          r_shift_en;

   logic          w_tc;
   logic          w_frame_end;
   logic [3:0]    w_code;
   logic [7:0]    w_seg;
   logic [3:0]    w_an_digit;

   assign w_tc        = i_en && (r_presc == PRESC_LAST);
   assign w_frame_end = w_tc && (r_idx == 2'd3);
   assign w_code      = r_snap[r_idx];
   assign w_an_digit  = ~(4'b1000 >> r_idx);

   char_to_seg7 u_char_to_seg7 (
      .i_code (w_code),
      .o_seg  (w_seg)
   );

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_presc    <= '0;
         r_idx      <= 2'd0;
         r_fcnt     <= '0;
         for (int i = 0; i < 4; i++) begin
            r_snap[i] <= CH_BLANK;
         end
         r_seg      <= SEG_OFF;
         r_an       <= AN_OFF;
         r_shift_en <= 1'b0;
      end else begin
         r_shift_en <= 1'b0;

         if (w_tc) begin
            r_presc <= '0;
            r_idx   <= r_idx + 2'd1;
         end else if (i_en) begin
            r_presc <= r_presc + 1'b1;
         end

         // Snapshot only at the frame boundary so a frame never mixes old and new text.
         if (w_frame_end) begin
            r_snap[0] <= i_c0;
            r_snap[1] <= i_c1;
            r_snap[2] <= i_c2;
            r_snap[3] <= i_c3;
            if (r_fcnt == FCNT_LAST) begin
               r_fcnt     <= '0;
               r_shift_en <= 1'b1;
            end else begin
               r_fcnt <= r_fcnt + 1'b1;
            end
         end

         r_an  <= (i_en && (r_presc >= BLANK_END)) ? w_an_digit : AN_OFF;
         r_seg <= i_en ? w_seg : SEG_OFF;
      end
   end

   assign o_seg      = r_seg;
   assign o_an       = r_an;
   assign o_shift_en = r_shift_en;

endmodule

// File: tb/tb_scroll_display_scan.sv
// Directed bench for scroll_display_scan with SCAN_DIV=4, BLANK_CYC=1, FRAMES_PER_SHIFT=2.
module tb_scroll_display_scan;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       en = 1'b0;
   logic [3:0] c0 = 4'd0;
   logic [3:0] c1 = 4'd0;
   logic [3:0] c2 = 4'd0;
   logic [3:0] c3 = 4'd0;
   logic [7:0] seg;
   logic [3:0] an;
   logic       shift_en;

   int tests = 0;
   int fails = 0;
   int k = 0;   // index of the last clock edge since reset release

   // Expected seg per digit: frame showing F L A S, then F H A S.
   logic [7:0] seg_flas [4] = '{8'h8E, 8'hC7, 8'h88, 8'h92};
   logic [7:0] seg_fhas [4] = '{8'h8E, 8'h89, 8'h88, 8'h92};

   scroll_display_scan #(
      .SCAN_DIV         (4),
      .BLANK_CYC        (1),
      .FRAMES_PER_SHIFT (2)
   ) dut (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_en       (en),
      .i_c0       (c0),
      .i_c1       (c1),
      .i_c2       (c2),
      .i_c3       (c3),
      .o_seg      (seg),
      .o_an       (an),
      .o_shift_en (shift_en)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
      k = k + 1;
   endtask

   // Anode pattern expected after edge kk of an uninterrupted scan.
   function automatic logic [3:0] exp_an(input int kk);
      logic [3:0] msb;
      msb = 4'b1000;
      if (kk % 4 == 0) return 4'hF;
      return ~(msb >> ((kk / 4) % 4));
   endfunction

   task automatic test_reset();
      rst_n = 1'b0;
      en = 1'b1;
      c0 = 4'd3; c1 = 4'd7; c2 = 4'd0; c3 = 4'd10;
      repeat (3) tick();
      tests++; if (seg !== 8'hFF) begin fails++; $display("FAIL reset_seg got %h exp ff", seg); end
      tests++; if (an !== 4'hF) begin fails++; $display("FAIL reset_an got %b exp 1111", an); end
      tests++; if (shift_en !== 1'b0) begin fails++; $display("FAIL reset_shift got %b exp 0", shift_en); end
      rst_n = 1'b1;
      k = -1;
   endtask

   task automatic test_first_frame();
      for (int i = 0; i < 16; i++) begin
         tick();
         tests++; if (an !== exp_an(k)) begin fails++; $display("FAIL frame1_an k=%0d got %b exp %b", k, an, exp_an(k)); end
         tests++; if (seg !== 8'hFF) begin fails++; $display("FAIL frame1_seg k=%0d got %h exp ff", k, seg); end
         tests++; if (shift_en !== 1'b0) begin fails++; $display("FAIL frame1_shift k=%0d got %b exp 0", k, shift_en); end
      end
   endtask

   task automatic test_second_frame();
      for (int i = 0; i < 16; i++) begin
         tick();
         if (k == 21) c1 = 4'd5;
         tests++; if (an !== exp_an(k)) begin fails++; $display("FAIL frame2_an k=%0d got %b exp %b", k, an, exp_an(k)); end
         tests++; if (seg !== seg_flas[(k / 4) % 4]) begin fails++; $display("FAIL frame2_seg k=%0d got %h exp %h", k, seg, seg_flas[(k / 4) % 4]); end
         tests++; if (shift_en !== (k == 31)) begin fails++; $display("FAIL frame2_shift k=%0d got %b exp %b", k, shift_en, (k == 31)); end
      end
   endtask

   task automatic test_snapshot_update();
      for (int i = 0; i < 16; i++) begin
         tick();
         tests++; if (an !== exp_an(k)) begin fails++; $display("FAIL frame3_an k=%0d got %b exp %b", k, an, exp_an(k)); end
         tests++; if (seg !== seg_fhas[(k / 4) % 4]) begin fails++; $display("FAIL frame3_seg k=%0d got %h exp %h", k, seg, seg_fhas[(k / 4) % 4]); end
         tests++; if (shift_en !== 1'b0) begin fails++; $display("FAIL frame3_shift k=%0d got %b exp 0", k, shift_en); end
      end
   endtask

   task automatic test_shift_pace();
      int pulses;
      pulses = 0;
      while (k < 99) begin
         tick();
         if (shift_en === 1'b1) pulses++;
         tests++; if (shift_en !== (k % 32 == 31)) begin fails++; $display("FAIL pace_shift k=%0d got %b exp %b", k, shift_en, (k % 32 == 31)); end
      end
      tests++; if (pulses != 2) begin fails++; $display("FAIL pace_count got %0d exp 2", pulses); end
   endtask

   task automatic test_en_drop();
      repeat (6) tick();
      en = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         tests++; if (an !== 4'hF) begin fails++; $display("FAIL endrop_an i=%0d got %b exp 1111", i, an); end
         tests++; if (seg !== 8'hFF) begin fails++; $display("FAIL endrop_seg i=%0d got %h exp ff", i, seg); end
         tests++; if (shift_en !== 1'b0) begin fails++; $display("FAIL endrop_shift i=%0d got %b exp 0", i, shift_en); end
      end
      en = 1'b1;
      tick();
      tests++; if (an !== 4'b1101) begin fails++; $display("FAIL resume_an0 got %b exp 1101", an); end
      tests++; if (seg !== 8'h88) begin fails++; $display("FAIL resume_seg0 got %h exp 88", seg); end
      tick();
      tests++; if (an !== 4'b1101) begin fails++; $display("FAIL resume_an1 got %b exp 1101", an); end
      tests++; if (seg !== 8'h88) begin fails++; $display("FAIL resume_seg1 got %h exp 88", seg); end
      tick();
      tests++; if (an !== 4'hF) begin fails++; $display("FAIL resume_an2 got %b exp 1111", an); end
      tests++; if (seg !== 8'h92) begin fails++; $display("FAIL resume_seg2 got %h exp 92", seg); end
      tests++; if (shift_en !== 1'b0) begin fails++; $display("FAIL resume_shift got %b exp 0", shift_en); end
   endtask

   task automatic test_reset_pulse();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tests++; if (an !== 4'hF) begin fails++; $display("FAIL rstpulse_an got %b exp 1111", an); end
      tests++; if (seg !== 8'hFF) begin fails++; $display("FAIL rstpulse_seg got %h exp ff", seg); end
      tests++; if (shift_en !== 1'b0) begin fails++; $display("FAIL rstpulse_shift got %b exp 0", shift_en); end
      k = -1;
      for (int i = 0; i < 17; i++) begin
         tick();
         tests++; if (an !== exp_an(k)) begin fails++; $display("FAIL rst_frame_an k=%0d got %b exp %b", k, an, exp_an(k)); end
         tests++; if (seg !== ((k < 16) ? 8'hFF : 8'h8E)) begin fails++; $display("FAIL rst_frame_seg k=%0d got %h exp %h", k, seg, ((k < 16) ? 8'hFF : 8'h8E)); end
         tests++; if (shift_en !== 1'b0) begin fails++; $display("FAIL rst_frame_shift k=%0d got %b exp 0", k, shift_en); end
      end
   endtask

   task automatic test_blank_chars();
      c0 = 4'd15; c1 = 4'd15; c2 = 4'd15; c3 = 4'd15;
      while (k < 47) begin
         tick();
         tests++; if (an !== exp_an(k)) begin fails++; $display("FAIL blank_an k=%0d got %b exp %b", k, an, exp_an(k)); end
         tests++; if (shift_en !== (k == 31)) begin fails++; $display("FAIL blank_shift k=%0d got %b exp %b", k, shift_en, (k == 31)); end
         if (k >= 32) begin
            tests++; if (seg !== 8'hFF) begin fails++; $display("FAIL blank_seg k=%0d got %h exp ff", k, seg); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_first_frame();
      test_second_frame();
      test_snapshot_update();
      test_shift_pace();
      test_en_drop();
      test_reset_pulse();
      test_blank_chars();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
